// File: rtl/nn_ops_pkg.sv
// Shared constants, stage payload type and saturation helper for the NN non-linear ops datapath.
package nn_ops_pkg;

    localparam int DEF_IN_WIDTH    = 32;
    localparam int DEF_MULT_WIDTH  = 32;
    localparam int DEF_SHIFT_WIDTH = 6;
    localparam int DEF_OUT_WIDTH   = 8;
    localparam int DEF_PW          = DEF_IN_WIDTH + DEF_MULT_WIDTH + 1;

    typedef struct packed {
        logic [DEF_PW-1:0]        q;
        logic [DEF_OUT_WIDTH-1:0] zp;
    } requant_s2_t;

    // Returns {sat, clipped}: value clamped to a signed range of the given width.
    function automatic logic [DEF_OUT_WIDTH:0] sat_clip(input logic signed [DEF_PW:0] value,
                                                        input int width);
        logic signed [DEF_PW:0] maxV;
        logic signed [DEF_PW:0] minV;
        maxV = ({{DEF_PW{1'b0}}, 1'b1} << (width - 1)) - 1'b1;
        minV = ~maxV;
        if (value > maxV) begin
            sat_clip = {1'b1, maxV[DEF_OUT_WIDTH-1:0]};
        end else if (value < minV) begin
            sat_clip = {1'b1, minV[DEF_OUT_WIDTH-1:0]};
        end else begin
            sat_clip = {1'b0, value[DEF_OUT_WIDTH-1:0]};
        end
    endfunction

endpackage

// File: rtl/varshift.sv
// Combinational variable shifter: lr_i=1 arithmetic right shift, lr_i=0 logical left shift.
module varshift #(
    parameter int WIDTH = 32
) (
    input  logic             lr_i,
    input  logic [WIDTH-1:0] i1_i,
    input  logic [WIDTH-1:0] i2_i,
    output logic [WIDTH-1:0] res_o
);

    logic signed [WIDTH-1:0] arithRight;

    assign arithRight = $signed(i1_i) >>> i2_i;
    assign res_o      = lr_i ? arithRight : (i1_i << i2_i);

endmodule

// File: rtl/requant.sv
// Three-stage requantizer: multiply, round-half-up shift, add zero-point and saturate.
module requant
    import nn_ops_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int MULT_WIDTH  = DEF_MULT_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   requant_in_valid,
    output logic                   requant_in_ready,
    input  logic [IN_WIDTH-1:0]    requant_acc_i,
    input  logic [MULT_WIDTH-1:0]  requant_mult_i,
    input  logic [SHIFT_WIDTH-1:0] requant_shift_i,
    input  logic [OUT_WIDTH-1:0]   requant_zp_i,
    output logic                   requant_out_valid,
    input  logic                   requant_out_ready,
    output logic [OUT_WIDTH-1:0]   requant_o,
    output logic                   requant_sat_o,
    input  logic                   requant_clr,
    output logic [CNT_WIDTH-1:0]   requant_sat_cnt
);

    localparam int PW = IN_WIDTH + MULT_WIDTH + 1;

    logic ready1, ready2, ready3;
    logic s1Valid_q, s2Valid_q, s3Valid_q;

    logic signed [PW-1:0]    s1Prod_d, s1Prod_q;
    logic [SHIFT_WIDTH-1:0]  s1Shift_q;
    logic [OUT_WIDTH-1:0]    s1Zp_q;

    logic [PW-1:0]           s2Bias, s2Sum, s2Shifted;
    requant_s2_t             s2Data_d, s2Data_q;

    logic signed [PW:0]      s3Sum;
    logic [OUT_WIDTH:0]      s3Clip_d;
    logic [OUT_WIDTH-1:0]    s3Out_q;
    logic                    s3Sat_q;

    logic [CNT_WIDTH-1:0]    satCnt_d, satCnt_q;

    // A stage can take a new beat if it is empty or its contents move on this cycle.
    assign ready3 = !s3Valid_q || requant_out_ready;
    assign ready2 = !s2Valid_q || ready3;
    assign ready1 = !s1Valid_q || ready2;

    assign s1Prod_d = PW'($signed(requant_acc_i)) * PW'($signed(requant_mult_i));

    assign s2Bias = (s1Shift_q == '0) ? '0 : (PW'(1) << (s1Shift_q - 1'b1));
    assign s2Sum  = s1Prod_q + s2Bias;

    varshift #(
        .WIDTH (PW)
    ) u_varshift (
        .lr_i  (1'b1),
        .i1_i  (s2Sum),
        .i2_i  (PW'(s1Shift_q)),
        .res_o (s2Shifted)
    );

    assign s2Data_d.q  = s2Shifted;
    assign s2Data_d.zp = s1Zp_q;

    assign s3Sum    = {s2Data_q.q[PW-1], s2Data_q.q}
                    + {{(PW + 1 - OUT_WIDTH){s2Data_q.zp[OUT_WIDTH-1]}}, s2Data_q.zp};
    assign s3Clip_d = sat_clip(s3Sum, OUT_WIDTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            s3Valid_q <= 1'b0;
            s1Prod_q  <= '0;
            s1Shift_q <= '0;
            s1Zp_q    <= '0;
            s2Data_q  <= '0;
            s3Out_q   <= '0;
            s3Sat_q   <= 1'b0;
        end else begin
            if (ready1) begin
                s1Valid_q <= requant_in_valid;
                if (requant_in_valid) begin
                    s1Prod_q  <= s1Prod_d;
                    s1Shift_q <= requant_shift_i;
                    s1Zp_q    <= requant_zp_i;
                end
            end
            if (ready2) begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    s2Data_q <= s2Data_d;
                end
            end
            if (ready3) begin
                s3Valid_q <= s2Valid_q;
                if (s2Valid_q) begin
                    s3Out_q <= s3Clip_d[OUT_WIDTH-1:0];
                    s3Sat_q <= s3Clip_d[OUT_WIDTH];
                end
            end
        end
    end

    // Clear wins over a same-cycle clipped delivery; the count saturates instead of wrapping.
    always_comb begin
        satCnt_d = satCnt_q;
        if (requant_clr) begin
            satCnt_d = '0;
        end else if (s3Valid_q && requant_out_ready && s3Sat_q && (satCnt_q != '1)) begin
            satCnt_d = satCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            satCnt_q <= '0;
        end else begin
            satCnt_q <= satCnt_d;
        end
    end

    assign requant_in_ready  = ready1;
    assign requant_out_valid = s3Valid_q;
    assign requant_o         = s3Out_q;
    assign requant_sat_o     = s3Sat_q;
    assign requant_sat_cnt   = satCnt_q;

endmodule

// File: tb/tb_requant.sv
// Directed-vector bench for requant: rounding, saturation, counter, backpressure and reset.
module tb_requant;

    logic               clk;
    logic               rst_n;
    logic               inValid;
    logic               inReady;
    logic signed [31:0] acc;
    logic signed [31:0] mult;
    logic [5:0]         shift;
    logic signed [7:0]  zp;
    logic               outValid;
    logic               outReady;
    logic signed [7:0]  reqOut;
    logic               satOut;
    logic               clr;
    logic [15:0]        satCnt;

    int vecCount  = 0;
    int missCount = 0;

    requant dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .requant_in_valid  (inValid),
        .requant_in_ready  (inReady),
        .requant_acc_i     (acc),
        .requant_mult_i    (mult),
        .requant_shift_i   (shift),
        .requant_zp_i      (zp),
        .requant_out_valid (outValid),
        .requant_out_ready (outReady),
        .requant_o         (reqOut),
        .requant_sat_o     (satOut),
        .requant_clr       (clr),
        .requant_sat_cnt   (satCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        vecCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One isolated beat with out_ready high; optionally pulses clr as the result is delivered.
    task automatic applyStimulus(input string tag, input logic signed [31:0] a,
                                 input logic signed [31:0] m, input logic [5:0] s,
                                 input logic signed [7:0] z, input longint expOut,
                                 input longint expSat, input bit clrAtOut);
        int lat;
        @(negedge clk);
        inValid = 1'b1;
        acc     = a;
        mult    = m;
        shift   = s;
        zp      = z;
        #1;
        checkOutput({tag, "_inrdy"}, inReady, 1);
        @(negedge clk);
        inValid = 1'b0;
        acc     = 32'sh5A5A5A5A;
        mult    = 32'sh7FFFFFFF;
        shift   = 6'd1;
        zp      = 8'sd77;
        lat     = 1;
        while (!outValid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 3);
        checkOutput({tag, "_out"}, reqOut, expOut);
        checkOutput({tag, "_sat"}, satOut, expSat);
        if (clrAtOut) clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int nextAcc;
        int got;
        int gaps;
        int seen;
        rst_n    = 1'b0;
        inValid  = 1'b0;
        acc      = '0;
        mult     = '0;
        shift    = '0;
        zp       = '0;
        outReady = 1'b1;
        clr      = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_valid", outValid, 0);
        checkOutput("reset_out", reqOut, 0);
        checkOutput("reset_sat", satOut, 0);
        checkOutput("reset_cnt", satCnt, 0);
        rst_n = 1'b1;

        applyStimulus("pass", 100, 1, 6'd0, 8'sd0, 100, 0, 1'b0);
        checkOutput("pass_cnt", satCnt, 0);

        applyStimulus("rnd_pos", 5, 3, 6'd2, 8'sd0, 4, 0, 1'b0);
        applyStimulus("rnd_neg", -5, 3, 6'd2, 8'sd0, -4, 0, 1'b0);
        applyStimulus("rnd_zp", 6, 1, 6'd2, -8'sd3, -1, 0, 1'b0);

        applyStimulus("sat_hi", 1000, 1, 6'd0, 8'sd0, 127, 1, 1'b0);
        applyStimulus("sat_lo", -1000, 1, 6'd0, 8'sd0, -128, 1, 1'b0);
        checkOutput("sat_cnt2", satCnt, 2);
        applyStimulus("sat_clr", 1000, 1, 6'd0, 8'sd0, 127, 1, 1'b1);
        checkOutput("sat_cnt_clr", satCnt, 0);

        applyStimulus("ovf", 32'sh80000000, 32'sh80000000, 6'd63, 8'sd0, 1, 0, 1'b0);

        // Backpressure: fill with out_ready low, then drain.
        outReady = 1'b0;
        nextAcc  = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            inValid = (nextAcc <= 5);
            acc     = nextAcc;
            mult    = 1;
            shift   = 6'd0;
            zp      = 8'sd0;
            #1;
            checkOutput("bp_in_ready", inReady, (c < 3) ? 1 : 0);
            if (c >= 3) begin
                checkOutput("bp_hold_valid", outValid, 1);
                checkOutput("bp_hold_data", reqOut, 1);
            end
            if (inValid && inReady) nextAcc++;
        end
        checkOutput("bp_accepted", nextAcc - 1, 3);

        got  = 0;
        gaps = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            @(negedge clk);
            outReady = 1'b1;
            inValid  = (nextAcc <= 5);
            acc      = nextAcc;
            #1;
            if (outValid) begin
                checkOutput("bp_order", reqOut, got + 1);
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            if (inValid && inReady) nextAcc++;
        end
        inValid = 1'b0;
        checkOutput("bp_count", got, 5);
        checkOutput("bp_gaps", gaps, 0);
        checkOutput("bp_all_in", nextAcc, 6);

        // Reset with three beats in flight.
        applyStimulus("pre_rst", 1000, 1, 6'd0, 8'sd0, 127, 1, 1'b0);
        checkOutput("pre_rst_cnt", satCnt, 1);
        outReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            inValid = 1'b1;
            acc     = 7 + c;
            mult    = 1;
            shift   = 6'd0;
            zp      = 8'sd0;
        end
        @(negedge clk);
        inValid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_mid_valid", outValid, 0);
        checkOutput("rst_mid_cnt", satCnt, 0);
        outReady = 1'b1;
        seen     = 0;
        repeat (6) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        checkOutput("rst_mid_stale", seen, 0);
        applyStimulus("post_rst", 20, 1, 6'd0, 8'sd0, 20, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
